// File: rtl/cache_repl_policy.sv
// Per-set cache replacement policy: tree-PLRU, LFSR random or round-robin victim
// selection, with any invalid way always taking precedence over the policy choice.
module cache_repl_policy #(
    parameter int NUMWAYS   = 4,
    parameter int SETLEN    = 7,
    parameter int NUMLINES  = 128,
    parameter int REPL_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CacheEn,
    input  logic               FlushStage,
    input  logic               LRUWriteEn,
    input  logic               SetValid,
    input  logic               ClearValid,
    input  logic               InvalidateCache,
    input  logic [NUMWAYS-1:0] HitWay,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [SETLEN-1:0]  CacheSetTag,
    input  logic [SETLEN-1:0]  PAdrSet,
    output logic [NUMWAYS-1:0] VictimWay
);
    localparam int LOGW = $clog2(NUMWAYS);

    logic [LOGW-1:0] policy_idx;
    logic [LOGW-1:0] victim_idx;
    logic [LOGW-1:0] inv_idx;
    logic            any_invalid;
    logic            commit;
    logic            unused_clear;

    // Invalidating a line does not touch replacement state.
    assign unused_clear = ClearValid;

    assign commit = LRUWriteEn & ~FlushStage & ~InvalidateCache & ((|HitWay) | SetValid);

    always_comb begin
        inv_idx = '0;
        for (int i = NUMWAYS - 1; i >= 0; i--) begin
            if (!ValidWay[i]) inv_idx = LOGW'(i);
        end
    end

    assign any_invalid = ~&ValidWay;
    assign victim_idx  = any_invalid ? inv_idx : policy_idx;

    always_comb begin
        VictimWay             = '0;
        VictimWay[victim_idx] = 1'b1;
    end

    generate
        if (REPL_MODE == 1) begin : g_lfsr
            logic [15:0] lfsr_q;
            logic [15:0] lfsr_d;
            logic        unused_rd;

            assign unused_rd = ^{CacheEn, CacheSetTag, PAdrSet};
            assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

            always_ff @(posedge clk) begin
                if (reset) begin
                    lfsr_q <= 16'h0001;
                end else if (commit && SetValid) begin
                    lfsr_q <= lfsr_d;
                end
            end

            assign policy_idx = lfsr_q[LOGW-1:0];
        end else begin : g_table
            localparam int EW = (REPL_MODE == 0) ? NUMWAYS - 1 : LOGW;

            logic [EW-1:0] mem_q [NUMLINES];
            logic [EW-1:0] rd_q;
            logic [EW-1:0] rd_d;
            logic [EW-1:0] upd_entry;
            logic          we;

            if (REPL_MODE == 0) begin : g_plru
                // Heap-ordered tree: node n has children 2n+1 / 2n+2, and the root
                // splits on the way-index LSB, deeper levels on successively higher bits.
                logic [LOGW-1:0] walk_node;
                logic [LOGW-1:0] upd_node;
                logic [LOGW-1:0] hit_idx;
                logic [LOGW-1:0] acc_idx;

                always_comb begin
                    walk_node  = '0;
                    policy_idx = '0;
                    for (int d = 0; d < LOGW; d++) begin
                        policy_idx[d] = rd_q[walk_node];
                        walk_node     = walk_node + walk_node + LOGW'(1) + LOGW'(rd_q[walk_node]);
                    end
                end

                always_comb begin
                    hit_idx = '0;
                    for (int i = 0; i < NUMWAYS; i++) begin
                        if (HitWay[i]) hit_idx = hit_idx | LOGW'(i);
                    end
                end

                assign acc_idx = SetValid ? victim_idx : hit_idx;

                always_comb begin
                    upd_node  = '0;
                    upd_entry = rd_q;
                    for (int d = 0; d < LOGW; d++) begin
                        upd_entry[upd_node] = ~acc_idx[d];
                        upd_node            = upd_node + upd_node + LOGW'(1) + LOGW'(acc_idx[d]);
                    end
                end

                assign we = commit;
            end else begin : g_rr
                assign policy_idx = rd_q;
                assign upd_entry  = rd_q + EW'(1);
                assign we         = commit & SetValid;
            end

            // Write-first: a commit to the set being read is visible in the same edge.
            assign rd_d = InvalidateCache ? '0 :
                          (we && (PAdrSet == CacheSetTag)) ? upd_entry : mem_q[CacheSetTag];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < NUMLINES; i++) mem_q[i] <= '0;
                    rd_q <= '0;
                end else begin
                    if (InvalidateCache) begin
                        for (int i = 0; i < NUMLINES; i++) mem_q[i] <= '0;
                    end else if (we) begin
                        mem_q[PAdrSet] <= upd_entry;
                    end
                    if (CacheEn) rd_q <= rd_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cache_repl_policy.sv
// Directed bench for cache_repl_policy: one instance per replacement mode, all
// driven by the same stimulus, each checked against hand-derived victims.
module tb_cache_repl_policy;
    logic       clk;
    logic       reset;
    logic       CacheEn;
    logic       FlushStage;
    logic       LRUWriteEn;
    logic       SetValid;
    logic       ClearValid;
    logic       InvalidateCache;
    logic [3:0] HitWay;
    logic [3:0] ValidWay;
    logic [6:0] CacheSetTag;
    logic [6:0] PAdrSet;
    logic [3:0] vw0;
    logic [3:0] vw1;
    logic [3:0] vw2;

    int total = 0;
    int bad   = 0;

    logic [3:0]  exp_q[$];
    logic [15:0] lfsr_m;
    logic [3:0]  cur_exp;

    cache_repl_policy #(.NUMWAYS(4), .SETLEN(7), .NUMLINES(128), .REPL_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .CacheEn(CacheEn), .FlushStage(FlushStage),
        .LRUWriteEn(LRUWriteEn), .SetValid(SetValid), .ClearValid(ClearValid),
        .InvalidateCache(InvalidateCache), .HitWay(HitWay), .ValidWay(ValidWay),
        .CacheSetTag(CacheSetTag), .PAdrSet(PAdrSet), .VictimWay(vw0)
    );

    cache_repl_policy #(.NUMWAYS(4), .SETLEN(7), .NUMLINES(128), .REPL_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .CacheEn(CacheEn), .FlushStage(FlushStage),
        .LRUWriteEn(LRUWriteEn), .SetValid(SetValid), .ClearValid(ClearValid),
        .InvalidateCache(InvalidateCache), .HitWay(HitWay), .ValidWay(ValidWay),
        .CacheSetTag(CacheSetTag), .PAdrSet(PAdrSet), .VictimWay(vw1)
    );

    cache_repl_policy #(.NUMWAYS(4), .SETLEN(7), .NUMLINES(128), .REPL_MODE(2)) dut2 (
        .clk(clk), .reset(reset), .CacheEn(CacheEn), .FlushStage(FlushStage),
        .LRUWriteEn(LRUWriteEn), .SetValid(SetValid), .ClearValid(ClearValid),
        .InvalidateCache(InvalidateCache), .HitWay(HitWay), .ValidWay(ValidWay),
        .CacheSetTag(CacheSetTag), .PAdrSet(PAdrSet), .VictimWay(vw2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        CacheEn         = 1'b0;
        FlushStage      = 1'b0;
        LRUWriteEn      = 1'b0;
        SetValid        = 1'b0;
        ClearValid      = 1'b0;
        InvalidateCache = 1'b0;
        HitWay          = 4'b0000;
    endtask

    task automatic read_set(input logic [6:0] s);
        clr_ctl();
        CacheEn     = 1'b1;
        CacheSetTag = s;
        cyc();
        clr_ctl();
    endtask

    task automatic access(input logic [6:0] s, input logic [3:0] hw, input logic fill, input logic flush);
        clr_ctl();
        CacheEn     = 1'b1;
        CacheSetTag = s;
        PAdrSet     = s;
        LRUWriteEn  = 1'b1;
        HitWay      = hw;
        SetValid    = fill;
        FlushStage  = flush;
        cyc();
        clr_ctl();
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    initial begin
        clr_ctl();
        reset       = 1'b1;
        ValidWay    = 4'b1111;
        CacheSetTag = 7'd0;
        PAdrSet     = 7'd0;

        // reset held while a fill commit and a read are also requested
        CacheEn    = 1'b1;
        LRUWriteEn = 1'b1;
        SetValid   = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        clr_ctl();
        #1;
        check("reset_plru", vw0, 4'b0001);
        check("reset_lfsr", vw1, 4'b0010);
        check("reset_rr", vw2, 4'b0001);

        // invalid ways override every policy
        ValidWay = 4'b1011; #1;
        check("inv_1011_plru", vw0, 4'b0100);
        check("inv_1011_lfsr", vw1, 4'b0100);
        check("inv_1011_rr", vw2, 4'b0100);
        ValidWay = 4'b0000; #1;
        check("inv_0000_lfsr", vw1, 4'b0001);
        ValidWay = 4'b0111; #1;
        check("inv_0111_plru", vw0, 4'b1000);
        ValidWay = 4'b1111; #1;

        // PLRU: hits on ways 0,1,2 of set 3, checked straight after each commit
        read_set(7'd3);
        check("plru_set3_init", vw0, 4'b0001);
        access(7'd3, 4'b0001, 1'b0, 1'b0);
        check("plru_bypass_hit0", vw0, 4'b0010);
        access(7'd3, 4'b0010, 1'b0, 1'b0);
        check("plru_bypass_hit1", vw0, 4'b0100);
        access(7'd3, 4'b0100, 1'b0, 1'b0);
        check("plru_bypass_hit2", vw0, 4'b1000);
        check("rr_hits_no_change", vw2, 4'b0001);
        check("lfsr_hits_no_advance", vw1, 4'b0010);
        read_set(7'd3);
        check("plru_hits012", vw0, 4'b1000);

        // held read value while CacheEn is low
        CacheSetTag = 7'd5;
        cyc();
        check("plru_hold_no_en", vw0, 4'b1000);

        // suppressed updates: flush, empty hit, ClearValid, no write enable
        access(7'd3, 4'b0001, 1'b0, 1'b1);
        read_set(7'd3);
        check("plru_flush_no_update", vw0, 4'b1000);
        access(7'd3, 4'b0000, 1'b0, 1'b0);
        read_set(7'd3);
        check("plru_empty_hit", vw0, 4'b1000);
        clr_ctl();
        ClearValid  = 1'b1;
        CacheEn     = 1'b1;
        CacheSetTag = 7'd3;
        HitWay      = 4'b0001;
        cyc();
        clr_ctl();
        check("plru_clearvalid", vw0, 4'b1000);

        // PLRU fill into the invalid way 1, then all valid
        ValidWay = 4'b1101; #1;
        check("plru_fill_victim", vw0, 4'b0010);
        access(7'd3, 4'b0000, 1'b1, 1'b0);
        check("plru_after_fill_inv", vw0, 4'b0010);
        ValidWay = 4'b1111; #1;
        check("plru_after_fill", vw0, 4'b0001);
        check("rr_after_fill", vw2, 4'b0010);

        // invalidate wins over a simultaneous commit
        clr_ctl();
        CacheEn         = 1'b1;
        CacheSetTag     = 7'd3;
        PAdrSet         = 7'd3;
        LRUWriteEn      = 1'b1;
        HitWay          = 4'b0100;
        InvalidateCache = 1'b1;
        cyc();
        clr_ctl();
        check("plru_inval_rd", vw0, 4'b0001);
        read_set(7'd3);
        check("plru_inval_set3", vw0, 4'b0001);
        check("rr_inval_set3", vw2, 4'b0001);

        // round-robin on set 5 with wrap
        read_set(7'd5);
        check("rr_set5_init", vw2, 4'b0001);
        access(7'd5, 4'b0000, 1'b1, 1'b0);
        check("rr_fill1", vw2, 4'b0010);
        access(7'd5, 4'b0000, 1'b1, 1'b0);
        check("rr_fill2", vw2, 4'b0100);
        access(7'd5, 4'b0000, 1'b1, 1'b0);
        check("rr_fill3", vw2, 4'b1000);
        access(7'd5, 4'b0000, 1'b1, 1'b0);
        check("rr_fill4_wrap", vw2, 4'b0001);
        access(7'd5, 4'b0000, 1'b1, 1'b0);
        check("rr_fill5", vw2, 4'b0010);
        read_set(7'd6);
        check("rr_set6", vw2, 4'b0001);

        // reset in the same cycle as a pending fill discards it
        reset = 1'b1;
        access(7'd5, 4'b0000, 1'b1, 1'b0);
        reset = 1'b0;
        read_set(7'd5);
        check("rr_reset_discard", vw2, 4'b0001);
        check("lfsr_reset_reload", vw1, 4'b0010);

        // LFSR golden model over a run of fills
        lfsr_m = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            access(7'd9, 4'b0000, 1'b1, 1'b0);
            lfsr_m  = lfsr_step(lfsr_m);
            cur_exp = 4'b0001 << lfsr_m[1:0];
            exp_q.push_back(cur_exp);
            check("lfsr_fill", vw1, exp_q.pop_front());
        end

        clr_ctl();
        CacheEn         = 1'b1;
        LRUWriteEn      = 1'b1;
        SetValid        = 1'b1;
        InvalidateCache = 1'b1;
        cyc();
        clr_ctl();
        check("lfsr_inval_hold", vw1, cur_exp);
        access(7'd9, 4'b0001, 1'b0, 1'b0);
        check("lfsr_hit_hold", vw1, cur_exp);
        access(7'd9, 4'b0000, 1'b1, 1'b1);
        check("lfsr_flush_hold", vw1, cur_exp);
        access(7'd9, 4'b0000, 1'b1, 1'b0);
        lfsr_m  = lfsr_step(lfsr_m);
        cur_exp = 4'b0001 << lfsr_m[1:0];
        check("lfsr_fill_after_hold", vw1, cur_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_repl_policy.md
CACHE_REPL_POLICY -- requirements
Module: cachereplpolicy

Interface
REQ-001 Parameter NUMWAYS, default 4: ways per set; power of two, 2..16.
REQ-002 Parameter SETLEN, default 7: set index width.
REQ-003 Parameter NUMLINES, default 128: sets; equals 2**SETLEN.
REQ-004 Parameter REPL_MODE, default 0: 0 tree-PLRU, 1 LFSR random, 2 per-set round-robin.
REQ-005 Ports, one per line:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- CacheEn  in  1  state-array read enable.
- FlushStage  in  1  pipeline flush; suppresses all state updates.
- LRUWriteEn  in  1  commit replacement update for the current access.
- SetValid  in  1  line fill in progress; the victim way is being written.
- ClearValid  in  1  line invalidation; no policy effect.
- InvalidateCache  in  1  clear all policy state.
- HitWay  in  NUMWAYS  one-hot hit vector.
- ValidWay  in  NUMWAYS  valid bits of the addressed set.
- CacheSetTag  in  SETLEN  set index for state read.
- PAdrSet  in  SETLEN  set index for state write.
- VictimWay  out  NUMWAYS  one-hot victim selection.

Function
REQ-006 Storage: NUMLINES entries; entry width NUMWAYS-1 (mode 0), log2(NUMWAYS) (mode 2), none (mode 1).
REQ-007 Read: when CacheEn=1, the entry at CacheSetTag is registered on the clock edge. When CacheEn=0, the registered value is held.
REQ-008 Read-after-write bypass: an update written to the same set that is read in the same cycle is reflected in the registered value (write-first).
REQ-009 Invalid priority: if any ValidWay bit is 0, VictimWay is the one-hot of the lowest-index invalid way, in every mode.
REQ-010 Mode 0 victim: walk the tree from the root. Node bit 0 selects the lower-index subtree and 1 selects the upper. An all-zero entry selects way 0.
REQ-011 Mode 0 update: the accessed way is VictimWay if SetValid=1, otherwise HitWay. Every node on its path is set to point away from it.
REQ-012 Mode 1: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'h0001. Victim is the one-hot of LFSR[log2(NUMWAYS)-1:0]. The LFSR advances one step per committed fill.
REQ-013 Mode 2: victim is the one-hot of the stored pointer. A committed fill increments the pointer modulo NUMWAYS (wraps NUMWAYS-1 -> 0). Hits do not change the pointer.
REQ-014 Commit condition: updates happen only when LRUWriteEn=1, FlushStage=0, InvalidateCache=0, and (HitWay != 0 or SetValid=1). Writes go to entry PAdrSet on the next clock edge.
REQ-015 A hit with HitWay=0 and SetValid=0 does not update state.
REQ-016 ClearValid has no effect on policy state.
REQ-017 InvalidateCache=1 zeroes every entry in one cycle. It leaves the LFSR unchanged and takes priority over a simultaneous commit.
REQ-018 VictimWay is combinational from the registered entry, the LFSR and ValidWay. It is always exactly one-hot.
REQ-019 NUMWAYS=2 in mode 0 uses a single node bit. No other behavioural difference.

Reset
REQ-020 Reset zeroes all entries, the registered read value and the pointers. The LFSR loads 16'h0001.
REQ-021 Reset takes priority over InvalidateCache, commits and reads in the same cycle.
REQ-022 In the cycle after reset with ValidWay all ones, VictimWay=0001 in modes 0 and 2 (NUMWAYS=4), and 0010 in mode 1.
REQ-023 Reset asserted mid-operation discards any pending update.

Verification
REQ-024 Mode 0, NUMWAYS=4, set 3 all valid: hits on ways 0,1,2 in consecutive commits, then read set 3 -> VictimWay=1000.
REQ-025 Mode 2, set 5 all valid: 4 committed fills -> victims 0001,0010,0100,1000, then 0001 (wrap); set 6 still yields 0001.
REQ-026 Any mode, ValidWay=1011 -> VictimWay=0100 regardless of stored state.
REQ-027 Mode 0: hit on way 0 with LRUWriteEn=1 and FlushStage=1 -> entry unchanged; the next read yields the same victim as before.
REQ-028 Mode 0: write set 3 and read set 3 in the same cycle -> the registered value reflects the new entry.
REQ-029 Mode 0: after InvalidateCache pulse, read any set -> VictimWay=0001. Mode 1: after 3 fills, the victim sequence matches the LFSR golden model.
